// File: rtl/bus_pkg.sv
// Shared definitions for the internal 8-bit bus arbiter: sizes, FSM states
// and the fixed requester indices used by the datapath.
package bus_pkg;

    localparam int unsigned N_REQ    = 4;
    localparam int unsigned DATA_W   = 8;
    localparam int unsigned MAX_HOLD = 8;
    localparam int unsigned IDX_W    = $clog2(N_REQ);

    localparam int unsigned REQ_PC  = 0;
    localparam int unsigned REQ_ACC = 1;
    localparam int unsigned REQ_RAM = 2;
    localparam int unsigned REQ_IN  = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        TURN = 2'd2
    } state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request after rr_ptr,
// wrapping modulo N_REQ, as a one-hot vector plus its index.
module rr_pick #(
    parameter int unsigned N_REQ = bus_pkg::N_REQ
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] rr_ptr,
    output logic [N_REQ-1:0]         win_c,
    output logic [$clog2(N_REQ)-1:0] win_idx_c,
    output logic                     any_c
);
    import bus_pkg::*;

    localparam int unsigned PW = $clog2(N_REQ);

    // Scan farthest-to-nearest so the closest requester after rr_ptr is written last.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        win_idx_c = '0;
        any_c     = 1'b0;
        for (int unsigned k = N_REQ; k >= 1; k--) begin
            idx = (32'(rr_ptr) + k) % N_REQ;
            if (req[PW'(idx)]) begin
                win_idx_c = PW'(idx);
                any_c     = 1'b1;
            end
        end
        win_c = any_c ? (N_REQ'(1) << win_idx_c) : '0;
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner of the shared internal bus: registered one-hot grant,
// one-cycle turnaround between owners and max-hold preemption.
module bus_arbiter #(
    parameter int unsigned N_REQ    = bus_pkg::N_REQ,
    parameter int unsigned DATA_W   = bus_pkg::DATA_W,
    parameter int unsigned MAX_HOLD = bus_pkg::MAX_HOLD
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ-1:0]          rel,
    input  logic [N_REQ*DATA_W-1:0]   drv_data,
    output logic [N_REQ-1:0]          grant,
    output logic [$clog2(N_REQ)-1:0]  owner,
    output logic                      bus_valid,
    output logic [DATA_W-1:0]         bus_out,
    output logic                      preempt
);
    import bus_pkg::*;

    localparam int unsigned PW     = $clog2(N_REQ);
    localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);

    state_e             state_q, state_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [PW-1:0]      owner_q, owner_d;
    logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic               preempt_q, preempt_d;

    logic [N_REQ-1:0]   pick_win;
    logic [PW-1:0]      pick_idx;
    logic               pick_any;
    logic               contenders;
    logic               hold_full;

    rr_pick #(
        .N_REQ (N_REQ)
    ) u_rr_pick (
        .req       (req),
        .rr_ptr    (rr_ptr_q),
        .win_c     (pick_win),
        .win_idx_c (pick_idx),
        .any_c     (pick_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            owner_q    <= '0;
            rr_ptr_q   <= PW'(N_REQ - 1);
            hold_cnt_q <= '0;
            preempt_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            hold_cnt_q <= hold_cnt_d;
            preempt_q  <= preempt_d;
        end
    end

    assign contenders = |(req & ~grant_q);
    assign hold_full  = (hold_cnt_q == HOLD_W'(MAX_HOLD));

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        hold_cnt_d = hold_cnt_q;
        preempt_d  = 1'b0;

        case (state_q)
            // TURN arbitrates exactly like IDLE; the bus was already dark for one cycle.
            IDLE, TURN: begin
                grant_d    = '0;
                owner_d    = '0;
                hold_cnt_d = '0;
                state_d    = IDLE;
                if (pick_any) begin
                    state_d    = OWN;
                    grant_d    = pick_win;
                    owner_d    = pick_idx;
                    rr_ptr_d   = pick_idx;
                    hold_cnt_d = HOLD_W'(1);
                end
            end

            OWN: begin
                if (rel[owner_q] || !req[owner_q]) begin
                    state_d    = TURN;
                    grant_d    = '0;
                    owner_d    = '0;
                    hold_cnt_d = '0;
                end else if (hold_full && contenders) begin
                    state_d    = TURN;
                    grant_d    = '0;
                    owner_d    = '0;
                    hold_cnt_d = '0;
                    preempt_d  = 1'b1;
                end else if (!hold_full) begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end

            default: begin
                state_d    = IDLE;
                grant_d    = '0;
                owner_d    = '0;
                hold_cnt_d = '0;
            end
        endcase
    end

    assign grant     = grant_q;
    assign owner     = owner_q;
    assign preempt   = preempt_q;
    assign bus_valid = |grant_q;

    // AND-OR steering; a zero grant yields a zero bus.
    always_comb begin
        bus_out = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            bus_out = bus_out | (drv_data[i*DATA_W +: DATA_W] & {DATA_W{grant_q[i]}});
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: arbitration order, turnaround, preemption,
// owner drop, non-owner release and asynchronous reset.
module tb_bus_arbiter;
    import bus_pkg::*;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req   = '0;
    logic [3:0]  rel   = '0;
    logic [31:0] drv_data;
    logic [3:0]  grant;
    logic [1:0]  owner;
    logic        bus_valid;
    logic [7:0]  bus_out;
    logic        preempt;

    int n_cmp = 0;
    int n_bad = 0;

    bus_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .rel       (rel),
        .drv_data  (drv_data),
        .grant     (grant),
        .owner     (owner),
        .bus_valid (bus_valid),
        .bus_out   (bus_out),
        .preempt   (preempt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_bus(input logic [3:0] g);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) if (g[i]) r = drv_data[i*8 +: 8];
        return r;
    endfunction

    function automatic logic [1:0] exp_owner(input logic [3:0] g);
        logic [1:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) if (g[i]) r = 2'(i);
        return r;
    endfunction

    task automatic chk_state(input string tag, input logic [3:0] g, input logic p);
        chk({tag, "/grant"},     32'(grant),     32'(g));
        chk({tag, "/owner"},     32'(owner),     32'(exp_owner(g)));
        chk({tag, "/bus_valid"}, 32'(bus_valid), 32'(|g));
        chk({tag, "/bus_out"},   32'(bus_out),   32'(exp_bus(g)));
        chk({tag, "/preempt"},   32'(preempt),   32'(p));
    endtask

    task automatic do_reset();
        req   = '0;
        rel   = '0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Continuous invariants while out of reset.
    always @(negedge clk) begin
        if (rst_n) begin
            n_cmp++;
            assert ($onehot0(grant)) else begin
                n_bad++;
                $error("FAIL onehot0: observed grant %b expected at most one bit set", grant);
            end
            n_cmp++;
            assert (bus_valid || bus_out === 8'h00) else begin
                n_bad++;
                $error("FAIL idle_bus_zero: observed bus_out %0h expected 0", bus_out);
            end
        end
    end

    initial begin
        drv_data = '0;
        drv_data[REQ_PC*8  +: 8] = 8'hC3;
        drv_data[REQ_ACC*8 +: 8] = 8'h5A;
        drv_data[REQ_RAM*8 +: 8] = 8'hA5;
        drv_data[REQ_IN*8  +: 8] = 8'h3C;

        // Reset values
        tick();
        chk_state("reset", 4'b0000, 1'b0);

        // 1: single requester, one-cycle grant latency
        rst_n = 1'b1;
        req   = 4'b0100;
        tick();
        chk_state("t1_grant", 4'b0100, 1'b0);
        chk("t1_bus_a5", 32'(bus_out), 32'h0000_00A5);
        req = 4'b0000;
        tick();
        chk_state("t1_drop", 4'b0000, 1'b0);

        // 2: all requesting, each owner releases after two cycles
        do_reset();
        req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            logic [3:0] g;
            g = 4'b0001 << (n % 4);
            tick();
            chk_state($sformatf("t2_own%0d_c1", n), g, 1'b0);
            tick();
            chk_state($sformatf("t2_own%0d_c2", n), g, 1'b0);
            rel = g;
            tick();
            rel = '0;
            chk_state($sformatf("t2_turn%0d", n), 4'b0000, 1'b0);
        end
        req = '0;
        tick();
        chk_state("t2_idle", 4'b0000, 1'b0);

        // 3: max-hold preemption with a contender
        do_reset();
        req = 4'b0001;
        tick();
        chk_state("t3_own_c1", 4'b0001, 1'b0);
        req = 4'b0011;
        for (int c = 2; c <= 8; c++) begin
            tick();
            chk_state($sformatf("t3_own_c%0d", c), 4'b0001, 1'b0);
        end
        tick();
        chk_state("t3_preempt", 4'b0000, 1'b1);
        tick();
        chk_state("t3_next", 4'b0010, 1'b0);

        // 4: lone owner never preempted; saturated hold preempts at once on contention
        do_reset();
        req = 4'b0001;
        for (int c = 1; c <= 20; c++) begin
            tick();
            chk_state($sformatf("t4_own_c%0d", c), 4'b0001, 1'b0);
        end
        req = 4'b0011;
        tick();
        chk_state("t4_sat_preempt", 4'b0000, 1'b1);
        tick();
        chk_state("t4_next", 4'b0010, 1'b0);

        // 5: non-owner rel ignored, owner drops req, release beats expiry
        do_reset();
        req = 4'b1000;
        tick();
        chk_state("t5_own3", 4'b1000, 1'b0);
        rel = 4'b0010;
        req = 4'b1010;
        tick();
        chk_state("t5_foreign_rel", 4'b1000, 1'b0);
        rel = '0;
        tick();
        chk_state("t5_hold", 4'b1000, 1'b0);
        req = 4'b0010;
        tick();
        chk_state("t5_drop_turn", 4'b0000, 1'b0);
        tick();
        chk_state("t5_own1", 4'b0010, 1'b0);
        req = 4'b0011;
        for (int c = 2; c <= 8; c++) begin
            tick();
            chk_state($sformatf("t5_own1_c%0d", c), 4'b0010, 1'b0);
        end
        rel = 4'b0010;
        tick();
        rel = '0;
        chk_state("t5_rel_vs_expiry", 4'b0000, 1'b0);
        tick();
        chk_state("t5_rr_after_rel", 4'b0001, 1'b0);

        // 6: asynchronous reset between edges while owned
        #3;
        rst_n = 1'b0;
        #1;
        chk_state("t6_async_rst", 4'b0000, 1'b0);
        req = 4'b1010;
        tick();
        rst_n = 1'b1;
        tick();
        chk_state("t6_first_after_rst", 4'b0010, 1'b0);

        req = '0;
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
